// File: rtl/alu_exec_stage_if.sv
// Decode -> execute -> memory/writeback bundle: operands and op in, registered result and flags out.
// Master drives operands and out_ready; slave (the execute stage) drives the handshake responses.
interface alu_exec_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, alu_op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, carry, ovf, illegal, busy
    );

    modport slave (
        input  in_valid, alu_op, a, b, out_ready,
        output in_ready, out_valid, result, zero, carry, ovf, illegal, busy
    );
endinterface

// File: rtl/alu_exec_stage.sv
// MIPS32 execute stage: 1-cycle ALU ops, shifts take n+1 cycles on a 1-bit/cycle shifter.
// Holds one result until out_ready; in_ready drops while shifting or while a result is stalled.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    alu_exec_stage_if.slave   ex_if
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shtype_t;

    state_t           state_q;
    shtype_t          sh_type_q, sh_type_d;
    logic [WIDTH-1:0] sreg_q, sreg_step;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] result_q, alu_res_d;
    logic             out_valid_q;
    logic             zero_q;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;
    logic             busy_q;
    logic             start_shift_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [SHW-1:0]   shamt;
    logic             in_ready_w;
    logic             accept;
    logic             slt_bit;
    logic             sltu_bit;

    assign shamt      = ex_if.b[SHW-1:0];
    assign in_ready_w = (state_q == IDLE) && (!out_valid_q || ex_if.out_ready);
    assign accept     = ex_if.in_valid && in_ready_w;

    // SUB as a + ~b + 1 so bit WIDTH is the MIPS-style NOT-borrow carry.
    assign sum_w    = {1'b0, ex_if.a} + {1'b0, ex_if.b};
    assign diff_w   = {1'b0, ex_if.a} + {1'b0, ~ex_if.b} + {{WIDTH{1'b0}}, 1'b1};
    assign slt_bit  = $signed(ex_if.a) < $signed(ex_if.b);
    assign sltu_bit = ex_if.a < ex_if.b;

    always_comb begin
        alu_res_d     = '0;
        carry_d       = 1'b0;
        ovf_d         = 1'b0;
        illegal_d     = 1'b0;
        start_shift_d = 1'b0;
        sh_type_d     = SH_LL;
        case (ex_if.alu_op)
            OP_ADD: begin
                alu_res_d = sum_w[WIDTH-1:0];
                carry_d   = sum_w[WIDTH];
                ovf_d     = (ex_if.a[WIDTH-1] == ex_if.b[WIDTH-1]) &&
                            (sum_w[WIDTH-1] != ex_if.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d = diff_w[WIDTH-1:0];
                carry_d   = diff_w[WIDTH];
                ovf_d     = (ex_if.a[WIDTH-1] != ex_if.b[WIDTH-1]) &&
                            (diff_w[WIDTH-1] != ex_if.a[WIDTH-1]);
            end
            OP_AND:  alu_res_d = ex_if.a & ex_if.b;
            OP_OR:   alu_res_d = ex_if.a | ex_if.b;
            OP_XOR:  alu_res_d = ex_if.a ^ ex_if.b;
            OP_NOR:  alu_res_d = ~(ex_if.a | ex_if.b);
            OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, sltu_bit};
            OP_SLL, OP_SRL, OP_SRA: begin
                // A zero shift amount completes like any single-cycle op.
                alu_res_d     = ex_if.a;
                start_shift_d = (shamt != '0);
                sh_type_d     = (ex_if.alu_op == OP_SLL) ? SH_LL :
                                (ex_if.alu_op == OP_SRL) ? SH_RL : SH_RA;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_comb begin
        sreg_step = sreg_q;
        case (sh_type_q)
            SH_LL:   sreg_step = {sreg_q[WIDTH-2:0], 1'b0};
            SH_RL:   sreg_step = {1'b0, sreg_q[WIDTH-1:1]};
            SH_RA:   sreg_step = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
            default: sreg_step = sreg_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            sreg_q      <= '0;
            cnt_q       <= '0;
            sh_type_q   <= SH_LL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (start_shift_d) begin
                            // in_ready guarantees any pending result is consumed this edge.
                            state_q     <= SHIFT;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                            sreg_q      <= ex_if.a;
                            cnt_q       <= shamt;
                            sh_type_q   <= sh_type_d;
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res_d;
                            zero_q      <= (alu_res_d == '0);
                            carry_q     <= carry_d;
                            ovf_q       <= ovf_d;
                            illegal_q   <= illegal_d;
                        end
                    end else if (out_valid_q && ex_if.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    sreg_q <= sreg_step;
                    cnt_q  <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        result_q    <= sreg_step;
                        zero_q      <= (sreg_step == '0);
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        illegal_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_if.in_ready  = in_ready_w;
    assign ex_if.out_valid = out_valid_q;
    assign ex_if.result    = result_q;
    assign ex_if.zero      = zero_q;
    assign ex_if.carry     = carry_q;
    assign ex_if.ovf       = ovf_q;
    assign ex_if.illegal   = illegal_q;
    assign ex_if.busy      = busy_q;
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage of the MIPS32 datapath. It accepts operand pairs and an operation code from decode and computes the result using the 32-bit bitwise units and the adder.
- Shifts run on an iterative 1-bit-per-cycle shifter.
- The registered result and flags go to the memory/writeback stage over a valid/ready handshake.

Parameters:
- WIDTH, 32: datapath width. Only 32 is supported.
- SHW, 5: shift-amount width, log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op valid.
- in_ready  output  1  stage can accept this cycle.
- alu_op  input  4  operation select; encoding below.
- a  input  32  operand A (rs).
- b  input  32  operand B (rt/imm); for shifts, b[4:0] is the shift amount.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  downstream consumes the result.
- result  output  32  registered result.
- zero  output  1  result == 0.
- carry  output  1  carry out of ADD; NOT borrow for SUB; 0 for all other ops.
- ovf  output  1  signed overflow on ADD/SUB; 0 for all other ops.
- illegal  output  1  alu_op was an undefined encoding.
- busy  output  1  shift in progress.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state: state=IDLE, out_valid=0, result=0, zero=0, carry=0, ovf=0, illegal=0, busy=0, and all internal shift/count registers 0.
- Reset mid-shift aborts the operation. Reset with a pending result discards that result.
- alu_op encoding:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed compare; result 32'h1 or 0.
  - 7 SLTU: unsigned compare.
  - 8 SLL, 9 SRL, 10 SRA: a shifted by b[4:0].
  - 11-15 illegal: result 0, illegal=1, single cycle.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A transfer occurs when in_valid && in_ready. Inputs are sampled only on a transfer.
  - out_valid stays high, with result and flags stable, until out_ready is sampled high.
  - Consumption and a new accept may occur in the same cycle.
- Flags:
  - zero is computed from the registered result for every op, including illegal.
  - carry is bit 32 of the 33-bit sum a+b for ADD, or of a+~b+1 for SUB.
  - ovf for ADD = (a[31]==b[31]) && (sum[31]!=a[31]).
  - ovf for SUB = (a[31]!=b[31]) && (diff[31]!=a[31]).
  - There are no traps; ovf is informational.
- Non-shift ops, and shifts with amount 0:
  - Result is registered on the accept edge. out_valid=1 in the cycle after accept, giving latency 1.
  - Shift by 0 returns a unchanged.
- Shift FSM, states IDLE and SHIFT:
  - IDLE -> SHIFT on accept of op 8/9/10 with n=b[4:0]>0. The accept edge loads sreg=a, cnt=n, and the shift type; busy=1 while in SHIFT.
  - Each SHIFT cycle shifts sreg by one bit and decrements cnt:
    - SLL: left shift, fill 0.
    - SRL: right shift, fill 0.
    - SRA: right shift, fill with sreg[31].
  - On the SHIFT edge where cnt==1, the shifted value is written to result, out_valid is set, and the FSM returns to IDLE.
  - Latency from accept to out_valid is n+1 cycles, so n=31 gives 32 cycles.
  - Entry to SHIFT requires out_valid to be clear or cleared at the same time (guaranteed by in_ready). The SHIFT-exit write therefore never overwrites a pending result.
  - in_ready=0 throughout SHIFT.
- in_valid while in_ready=0: no effect. The upstream holds its inputs.
- Backpressure: with out_ready held low, at most one result is held and no further accept occurs.
- Throughput: one result per cycle for non-shift ops when out_ready=1.

Test Plan:
- Reset: assert rst for 2 cycles during a 20-bit SRA -> next cycle out_valid=0, busy=0, in_ready=1, result=0.
- ADD overflow: a=32'h7FFFFFFF, b=1 -> 1 cycle later result=32'h80000000, ovf=1, carry=0, zero=0.
- SUB: a=5, b=5 -> result=0, zero=1, carry=1, ovf=0.
- SUB borrow: a=0, b=1 -> result=32'hFFFFFFFF, carry=0.
- OR/NOR: a=32'hF0F0F0F0, b=32'h0F0F0F0F -> OR result=32'hFFFFFFFF; NOR result=0 with zero=1.
- SLT vs SLTU: a=32'hFFFFFFFF, b=1 -> SLT=1, SLTU=0.
- SRA timing: a=32'h80000000, b=31, with in_valid at cycle T -> busy for cycles T+1..T+31; out_valid first high at T+32 with result=32'hFFFFFFFF; in_ready=0 until then.
- SLL by 0: a=32'h1234 -> result=32'h1234 after 1 cycle.
- Backpressure: out_ready=0 after an ADD result appears -> result stable for 5 cycles and in_ready=0. Then out_ready=1 together with in_valid for XOR -> same-cycle consume and accept, and the new result appears next cycle.
- Back-to-back: 4 consecutive ops AND, OR, XOR, illegal(12) with out_ready=1 -> 4 results on 4 consecutive cycles; the illegal op yields result=0, illegal=1, zero=1.
